fetch_stage: RTL

Instruction-fetch stage and the producer side of the IF/ID pipeline register. It owns the PC, issues single-outstanding reads to instruction memory, and buffers one returned word. It presents instr_F/PC_F/PCP4_F to IF/ID, which consumes the word on any edge with stall_F=0. Branch/jump redirects from EX discard in-flight and buffered fetches.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_ibuf.sv | 52 +++++
 rtl/fetch_stage.sv | 138 +++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : request FSM encoding (idle / waiting / dropping a stale response)
//   NOP_INSTR     : instruction presented to IF/ID when the fetch buffer is empty
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory read bus between the fetch stage and imem.
//   imem_req    : read request strobe (memory always accepts)
//   imem_addr   : request address, valid while imem_req=1
//   imem_rvalid : one response pulse per request, latency >= 1 cycle
//   imem_rdata  : response word
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_stage_if
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_ibuf.sv
// fetch_ibuf: one-entry instruction buffer feeding the IF/ID register.
//   clk, rst      : clock, asynchronous active-high reset
//   fill_i        : load fill_instr_i/fill_pc_i and mark valid
//   drain_i       : IF/ID consumed the entry this edge
//   flush_i       : discard the entry (redirect); overrides fill and drain
//   valid_o       : entry holds a real instruction
//   instr_o       : stored word, or NOP_INSTR when empty
//   pc_o          : address of the stored word (held after drain/flush)
module fetch_ibuf
  import fetch_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fill_i,
  input  logic             drain_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] fill_instr_i,
  input  logic [WIDTH-1:0] fill_pc_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;

  // A fill on the same edge as a drain wins: the old word leaves, the new one lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= RESET_PC;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      instr_q <= fill_instr_i;
      pc_q    <= fill_pc_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = valid_q ? instr_q : WIDTH'(NOP_INSTR);
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues single-outstanding instruction-memory reads
// and presents one buffered word to the IF/ID register.
//   clk, rst     : clock, asynchronous active-high reset (shared with imem)
//   stall_F      : IF/ID does not consume this cycle
//   redirect_E   : taken branch/jump from EX; flushes buffered and in-flight fetches
//   target_E     : redirect target address
//   imem         : fetch_stage_if.master (imem_req/imem_addr/imem_rvalid/imem_rdata)
//   instr_F      : buffered instruction or NOP
//   PC_F, PCP4_F : address of instr_F and that address + 4 (wraps)
//   valid_F      : buffer holds a real instruction
//   misaligned_F : sticky misaligned-redirect flag
// Build option FETCH_MISALIGN_EN: when defined, a misaligned redirect target is
// loaded as-is, raises misaligned_F and halts fetch until an aligned redirect.
// When undefined, target_E[1:0] is forced to zero and misaligned_F is tied low.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_F,
  input  logic               redirect_E,
  input  logic [WIDTH-1:0]   target_E,
  fetch_stage_if.master      imem,
  output logic [WIDTH-1:0]   instr_F,
  output logic [WIDTH-1:0]   PC_F,
  output logic [WIDTH-1:0]   PCP4_F,
  output logic               valid_F,
  output logic               misaligned_F
);

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [WIDTH-1:0] target_pc;
  logic             fetch_hold;
  logic             issue;
  logic             fill;
  logic             drain;
  logic             ibuf_valid;

`ifdef FETCH_MISALIGN_EN
  logic misaligned_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misaligned_q <= 1'b0;
    end else if (redirect_E) begin
      misaligned_q <= |target_E[1:0];
    end
  end

  assign target_pc    = target_E;
  assign fetch_hold   = misaligned_q;
  assign misaligned_F = misaligned_q;
`else
  assign target_pc    = target_E & ~WIDTH'(3);
  assign fetch_hold   = 1'b0;
  assign misaligned_F = 1'b0;
`endif

  // Issuing only when the buffer is empty or draining this edge guarantees the
  // response always has a free slot.
  assign issue = !rst && (state_q == FS_IDLE) && (!ibuf_valid || !stall_F)
                 && !redirect_E && !fetch_hold;
  assign fill  = (state_q == FS_WAIT) && imem.imem_rvalid && !redirect_E;
  assign drain = ibuf_valid && !stall_F;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      FS_IDLE: begin
        if (issue) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + WIDTH'(4);
          state_d  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        // A response arriving with a redirect is simply not filled.
        if (imem.imem_rvalid) begin
          state_d = FS_IDLE;
        end else if (redirect_E) begin
          state_d = FS_DROP;
        end
      end
      FS_DROP: begin
        // The stale response retires the drop even if another redirect lands.
        if (imem.imem_rvalid) begin
          state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (redirect_E) begin
      pc_d = target_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= FS_IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_ibuf #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_ibuf (
    .clk          (clk),
    .rst          (rst),
    .fill_i       (fill),
    .drain_i      (drain),
    .flush_i      (redirect_E),
    .fill_instr_i (imem.imem_rdata),
    .fill_pc_i    (req_pc_q),
    .valid_o      (ibuf_valid),
    .instr_o      (instr_F),
    .pc_o         (PC_F)
  );

  assign valid_F = ibuf_valid;
  assign PCP4_F  = PC_F + WIDTH'(4);

endmodule
